// File: rtl/clause_dispatcher.sv
// Engine-side clause dispatcher: accepts an in-order prefix of offered clauses
// into per-engine FIFOs round-robin, broadcasts the unit clause, flags drain.
module clause_dispatcher #(
    parameter int NUM_ENGINE      = 4,
    parameter int LIT_IDX_MAX     = 1024,
    parameter int CLA_LENGTH      = 3,
    parameter int VARIABLE_LENGTH = $clog2(LIT_IDX_MAX) + 1,
    parameter int CLAUSE_W        = VARIABLE_LENGTH * CLA_LENGTH,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start_in,
    input  logic                           empty_in,
    input  logic [$clog2(NUM_ENGINE):0]    clause_released_in,
    input  logic [NUM_ENGINE*CLAUSE_W-1:0] clause_in,
    input  logic [VARIABLE_LENGTH-1:0]     chosen_uc_in,
    input  logic                           chosen_uc_valid_in,
    output logic [$clog2(NUM_ENGINE):0]    clause_received_out,
    output logic [NUM_ENGINE*CLAUSE_W-1:0] eng_clause_out,
    output logic [NUM_ENGINE-1:0]          eng_clause_valid_out,
    input  logic [NUM_ENGINE-1:0]          eng_clause_ready_in,
    input  logic [NUM_ENGINE-1:0]          eng_busy_in,
    output logic [VARIABLE_LENGTH-1:0]     eng_uc_out,
    output logic                           eng_uc_valid_out,
    output logic                           done_out
);
    localparam int CNT_W = $clog2(NUM_ENGINE) + 1;
    localparam int PTR_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
    localparam int FP_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W = FP_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_next;

    logic [PTR_W-1:0]    rr_ptr, rr_next;
    logic [CLAUSE_W-1:0] offer [NUM_ENGINE];
    logic [CLAUSE_W-1:0] mem [NUM_ENGINE][FIFO_DEPTH];
    logic [FP_W-1:0]     wr_ptr [NUM_ENGINE];
    logic [FP_W-1:0]     rd_ptr [NUM_ENGINE];
    logic [OCC_W-1:0]    occ [NUM_ENGINE];
    logic [PTR_W-1:0]    push_sel [NUM_ENGINE];
    logic [NUM_ENGINE-1:0] push, pop;
    logic                fifos_empty;

    for (genvar g = 0; g < NUM_ENGINE; g++) begin : g_eng
        assign offer[g] = clause_in[g*CLAUSE_W +: CLAUSE_W];
        assign eng_clause_valid_out[g] = (occ[g] != '0);
        assign pop[g] = eng_clause_valid_out[g] & eng_clause_ready_in[g];
        assign eng_clause_out[g*CLAUSE_W +: CLAUSE_W] =
            eng_clause_valid_out[g] ? mem[g][rd_ptr[g]] : '0;
    end

    always_comb begin
        fifos_empty = 1'b1;
        for (int e = 0; e < NUM_ENGINE; e++)
            if (occ[e] != '0) fifos_empty = 1'b0;
    end

    // Single round-robin pass; acceptance looks only at registered occupancy.
    always_comb begin
        logic [CNT_W-1:0] taken;
        logic [PTR_W:0]   sum;
        logic [PTR_W:0]   nxt;
        logic [PTR_W-1:0] eidx;
        taken   = '0;
        sum     = '0;
        nxt     = '0;
        eidx    = '0;
        rr_next = rr_ptr;
        push    = '0;
        for (int e = 0; e < NUM_ENGINE; e++) push_sel[e] = '0;
        if (state == S_RUN && start_in) begin
            for (int k = 0; k < NUM_ENGINE; k++) begin
                sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(NUM_ENGINE))
                    sum = sum - (PTR_W+1)'(NUM_ENGINE);
                eidx = sum[PTR_W-1:0];
                if (taken < clause_released_in &&
                    occ[eidx] < OCC_W'(FIFO_DEPTH)) begin
                    push[eidx]     = 1'b1;
                    push_sel[eidx] = taken[PTR_W-1:0];
                    taken          = taken + 1'b1;
                    nxt            = {1'b0, eidx} + 1'b1;
                    rr_next        = (nxt == (PTR_W+1)'(NUM_ENGINE)) ?
                                     '0 : nxt[PTR_W-1:0];
                end
            end
        end
        clause_received_out = taken;
    end

    always_ff @(posedge clock) begin
        for (int e = 0; e < NUM_ENGINE; e++)
            if (push[e]) mem[e][wr_ptr[e]] <= offer[push_sel[e]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
            for (int e = 0; e < NUM_ENGINE; e++) begin
                wr_ptr[e] <= '0;
                rd_ptr[e] <= '0;
                occ[e]    <= '0;
            end
        end else begin
            rr_ptr <= rr_next;
            for (int e = 0; e < NUM_ENGINE; e++) begin
                if (push[e]) wr_ptr[e] <= wr_ptr[e] + 1'b1;
                if (pop[e])  rd_ptr[e] <= rd_ptr[e] + 1'b1;
                if (push[e] && !pop[e])      occ[e] <= occ[e] + 1'b1;
                else if (!push[e] && pop[e]) occ[e] <= occ[e] - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            eng_uc_out       <= '0;
            eng_uc_valid_out <= 1'b0;
        end else begin
            eng_uc_valid_out <= chosen_uc_valid_in;
            if (chosen_uc_valid_in) eng_uc_out <= chosen_uc_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start_in) state_next = S_RUN;
            S_RUN:   if (start_in && empty_in && clause_released_in == '0)
                         state_next = S_DRAIN;
            S_DRAIN: if (start_in && !empty_in)
                         state_next = S_RUN;
                     else if (fifos_empty && eng_busy_in == '0)
                         state_next = S_DONE;
            S_DONE:  if (!start_in) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        done_out = (state == S_DONE);
    end
endmodule

// File: tb/tb_clause_dispatcher.sv
// Randomized bench for clause_dispatcher against a queue-based reference model.
module tb_clause_dispatcher;
    localparam int N     = 4;
    localparam int VL    = 11;
    localparam int CW    = 33;
    localparam int DEPTH = 4;
    localparam int RW    = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

    logic          clock = 1'b0;
    logic          reset, start_in, empty_in;
    logic [RW-1:0] clause_released_in;
    logic [N*CW-1:0] clause_in;
    logic [VL-1:0] chosen_uc_in;
    logic          chosen_uc_valid_in;
    logic [RW-1:0] clause_received_out;
    logic [N*CW-1:0] eng_clause_out;
    logic [N-1:0]  eng_clause_valid_out, eng_clause_ready_in, eng_busy_in;
    logic [VL-1:0] eng_uc_out;
    logic          eng_uc_valid_out, done_out;

    clause_dispatcher dut (
        .clock(clock), .reset(reset), .start_in(start_in),
        .empty_in(empty_in), .clause_released_in(clause_released_in),
        .clause_in(clause_in), .chosen_uc_in(chosen_uc_in),
        .chosen_uc_valid_in(chosen_uc_valid_in),
        .clause_received_out(clause_received_out),
        .eng_clause_out(eng_clause_out),
        .eng_clause_valid_out(eng_clause_valid_out),
        .eng_clause_ready_in(eng_clause_ready_in),
        .eng_busy_in(eng_busy_in), .eng_uc_out(eng_uc_out),
        .eng_uc_valid_out(eng_uc_valid_out), .done_out(done_out)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [CW-1:0] q [N][$];
    int            m_state = M_IDLE;
    int            m_rr = 0;
    bit            m_ucv = 1'b0;
    logic [VL-1:0] m_uc = '0;

    task automatic step(input bit rst, input bit st, input bit emp,
                        input int rel, input logic [N-1:0] rdy,
                        input logic [N-1:0] bsy, input bit ucv,
                        input logic [VL-1:0] ucl);
        logic [CW-1:0] off [N];
        int take [N];
        int cnt, e, last;
        bit all_empty;
        @(negedge clock);
        for (int i = 0; i < N; i++) begin
            off[i] = CW'({$urandom, $urandom});
            clause_in[i*CW +: CW] = off[i];
        end
        reset = rst;
        start_in = st;
        empty_in = emp;
        clause_released_in = RW'(rel);
        eng_clause_ready_in = rdy;
        eng_busy_in = bsy;
        chosen_uc_valid_in = ucv;
        chosen_uc_in = ucl;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("valid%0d", i), eng_clause_valid_out[i],
                q[i].size() != 0);
            chk($sformatf("head%0d", i), eng_clause_out[i*CW +: CW],
                q[i].size() != 0 ? q[i][0] : '0);
        end
        chk("done", done_out, m_state == M_DONE);
        chk("uc_valid", eng_uc_valid_out, m_ucv);
        chk("uc", eng_uc_out, m_uc);
        cnt = 0;
        last = -1;
        for (int i = 0; i < N; i++) take[i] = -1;
        if (m_state == M_RUN && st)
            for (int k = 0; k < N; k++) begin
                e = (m_rr + k) % N;
                if (cnt < rel && q[e].size() < DEPTH) begin
                    take[e] = cnt;
                    cnt++;
                    last = e;
                end
            end
        chk("received", clause_received_out, cnt);
        if (rst) begin
            for (int i = 0; i < N; i++) q[i].delete();
            m_state = M_IDLE;
            m_rr = 0;
            m_ucv = 1'b0;
            m_uc = '0;
        end else begin
            all_empty = 1'b1;
            for (int i = 0; i < N; i++)
                if (q[i].size() != 0) all_empty = 1'b0;
            for (int i = 0; i < N; i++)
                if (rdy[i] && q[i].size() != 0) void'(q[i].pop_front());
            for (int i = 0; i < N; i++)
                if (take[i] >= 0) q[i].push_back(off[take[i]]);
            if (last >= 0) m_rr = (last + 1) % N;
            if (ucv) m_uc = ucl;
            m_ucv = ucv;
            case (m_state)
                M_IDLE:  if (st) m_state = M_RUN;
                M_RUN:   if (st && emp && rel == 0) m_state = M_DRAIN;
                M_DRAIN: if (st && !emp) m_state = M_RUN;
                         else if (all_empty && bsy == '0) m_state = M_DONE;
                default: if (!st) m_state = M_IDLE;
            endcase
        end
    endtask

    initial begin
        bit r_rst, r_st, r_emp, r_ucv;
        int r_rel;
        logic [N-1:0] r_rdy, r_bsy;
        reset = 1'b1;
        start_in = 1'b0;
        empty_in = 1'b0;
        clause_released_in = '0;
        clause_in = '0;
        chosen_uc_in = '0;
        chosen_uc_valid_in = 1'b0;
        eng_clause_ready_in = '0;
        eng_busy_in = '0;
        @(posedge clock);
        repeat (2) step(1, 0, 0, 0, '0, '0, 0, '0);
        step(0, 1, 0, 0, '0, '0, 0, '0);
        repeat (6) step(0, 1, 0, 4, '0, '0, 0, '0);
        step(0, 1, 0, 4, 4'b0010, '0, 0, '0);
        step(0, 1, 0, 4, '0, '0, 0, '0);
        step(0, 1, 0, 0, '0, '0, 1, 11'h405);
        repeat (2) step(0, 1, 0, 0, '0, '0, 0, '0);
        step(0, 1, 1, 0, '0, '0, 0, '0);
        step(0, 1, 1, 0, 4'hf, 4'b0100, 0, '0);
        repeat (6) step(0, 1, 1, 0, 4'hf, '0, 0, '0);
        repeat (2) step(0, 0, 0, 0, '0, '0, 0, '0);
        step(0, 1, 0, 0, '0, '0, 0, '0);
        step(0, 1, 0, 1, '0, '0, 0, '0);
        step(0, 1, 0, 1, '0, '0, 0, '0);
        repeat (4) step(0, 1, 0, 4, '0, '0, 0, '0);
        step(1, 1, 0, 4, '0, '0, 0, '0);
        step(0, 0, 0, 0, '0, '0, 0, '0);
        for (int c = 0; c < 800; c++) begin
            r_rst = ($urandom_range(0, 249) == 0);
            r_st  = ($urandom_range(0, 9) != 0);
            r_emp = ($urandom_range(0, 5) == 0);
            r_rel = r_emp ? 0 : $urandom_range(0, N);
            r_rdy = ((c / 100) % 2 == 1) ? N'($urandom) :
                    N'($urandom & $urandom & $urandom);
            r_bsy = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            r_ucv = ($urandom_range(0, 3) == 0);
            step(r_rst, r_st, r_emp, r_rel, r_rdy, r_bsy, r_ucv,
                 VL'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
